// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: synchronised, glitch-filtered frame receiver plus
// make/break/extended scancode decoder producing a held-key bitmap.
module ps2_key_tracker #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned FILT_LEN   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [12:0] held_keys,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int unsigned TO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);
  localparam int unsigned FW        = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  // Input synchronisers; idle bus level is high
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock filter: level changes only after FILT_LEN consecutive differing samples
  logic          filt_q;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q   <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt_q) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_q   <= clk_s2;
        filt_cnt <= '0;
        fall     <= filt_q;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  rx_state_t       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [12:0]     held_q, held_d;
  logic            bv_q, bv_d, fe_q, fe_d;
  logic [7:0]      bd_q, bd_d;
  logic            hit;
  logic [3:0]      idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      held_q    <= '0;
      bv_q      <= 1'b0;
      fe_q      <= 1'b0;
      bd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      held_q    <= held_d;
      bv_q      <= bv_d;
      fe_q      <= fe_d;
      bd_q      <= bd_d;
    end
  end

  // Scancode lookup keyed on {ext_flag, byte}
  always_comb begin
    hit = 1'b1;
    idx = 4'd0;
    case ({ext_q, shift_q})
      9'h016: idx = 4'd0;
      9'h01E: idx = 4'd1;
      9'h026: idx = 4'd2;
      9'h025: idx = 4'd3;
      9'h02E: idx = 4'd4;
      9'h036: idx = 4'd5;
      9'h03D: idx = 4'd6;
      9'h04E: idx = 4'd7;
      9'h055: idx = 4'd8;
      9'h175: idx = 4'd9;
      9'h172: idx = 4'd10;
      9'h16B: idx = 4'd11;
      9'h174: idx = 4'd12;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    held_d    = held_q;
    bd_d      = bd_q;
    bv_d      = 1'b0;
    fe_d      = 1'b0;
    to_cnt_d  = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + TO_W'(1);

    if (state_q != S_IDLE && !fall && to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
      fe_d     = 1'b1;
      state_d  = S_IDLE;
      to_cnt_d = '0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2 && (^{shift_q, par_q})) begin
            bv_d = 1'b1;
            bd_d = shift_q;
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shift_q == 8'h00 || shift_q == 8'hFF) begin
              held_d = '0;
              ext_d  = 1'b0;
              brk_d  = 1'b0;
            end else begin
              if (hit) held_d[idx] = ~brk_q;
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            fe_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign held_keys  = held_q;
  assign byte_valid = bv_q;
  assign byte_data  = bd_q;
  assign frame_err  = fe_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: table of single frames with expected
// bitmap/pulse counts, plus timeout, mid-frame reset and clock-glitch sequences.
module tb_ps2_key_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [12:0] held_keys;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int bv_tot   = 0;
  int fe_tot   = 0;

  typedef struct {
    logic [7:0]  code;
    logic        flip_par;
    logic [12:0] exp_held;
    int          exp_bv;
    int          exp_fe;
  } vec_t;

  vec_t vecs[$];

  // 1 MHz nominal => 200-cycle frame timeout
  ps2_key_tracker #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FILT_LEN(8)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .held_keys(held_keys), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) bv_tot++;
    if (frame_err) fe_tot++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, 20-cycle low phase; optional
  // 4-cycle low glitch in the preceding high phase.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(3); ps2_clk = 1'b0;
      wait_cyc(4); ps2_clk = 1'b1;
      wait_cyc(3);
    end else begin
      wait_cyc(10);
    end
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip, input int glitch_bit);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ flip, code, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_bit);
    ps2_data = 1'b1;
  endtask

  task automatic add(input logic [7:0] c, input logic f, input logic [12:0] h,
                     input int bv, input int fe);
    vec_t v;
    v.code = c; v.flip_par = f; v.exp_held = h; v.exp_bv = bv; v.exp_fe = fe;
    vecs.push_back(v);
  endtask

  initial begin
    int b0, f0;
    logic [7:0] prev_good;
    prev_good = 8'h00;

    add(8'h16, 0, 13'h0001, 1, 0);
    add(8'hF0, 0, 13'h0001, 1, 0);
    add(8'h16, 0, 13'h0000, 1, 0);
    add(8'hE0, 0, 13'h0000, 1, 0);
    add(8'h75, 0, 13'h0200, 1, 0);
    add(8'h75, 0, 13'h0200, 1, 0);  // keypad 8 without E0: unmapped
    add(8'hE0, 0, 13'h0200, 1, 0);
    add(8'hF0, 0, 13'h0200, 1, 0);
    add(8'h75, 0, 13'h0000, 1, 0);
    add(8'h1E, 1, 13'h0000, 0, 1);  // bad parity
    add(8'h16, 0, 13'h0001, 1, 0);
    add(8'h55, 0, 13'h0101, 1, 0);
    add(8'hE0, 0, 13'h0101, 1, 0);
    add(8'h75, 0, 13'h0301, 1, 0);
    add(8'h16, 0, 13'h0301, 1, 0);  // typematic repeat
    add(8'hF0, 0, 13'h0301, 1, 0);
    add(8'h25, 0, 13'h0301, 1, 0);  // break of key not held
    add(8'hFF, 0, 13'h0000, 1, 0);
    add(8'hE0, 0, 13'h0000, 1, 0);
    add(8'h16, 0, 13'h0000, 1, 0);  // E0+16 unmapped
    add(8'h4E, 0, 13'h0080, 1, 0);
    add(8'hE0, 0, 13'h0080, 1, 0);
    add(8'h72, 0, 13'h0480, 1, 0);
    add(8'hE0, 0, 13'h0480, 1, 0);
    add(8'h6B, 0, 13'h0C80, 1, 0);
    add(8'hE0, 0, 13'h0C80, 1, 0);
    add(8'h74, 0, 13'h1C80, 1, 0);
    add(8'h26, 0, 13'h1C84, 1, 0);
    add(8'h36, 0, 13'h1CA4, 1, 0);
    add(8'h00, 0, 13'h0000, 1, 0);

    wait_cyc(5);
    check("reset held", {19'd0, held_keys}, 32'h0);
    check("reset byte_valid", {31'd0, byte_valid}, 32'h0);
    check("reset byte_data", {24'd0, byte_data}, 32'h0);
    check("reset frame_err", {31'd0, frame_err}, 32'h0);
    rst = 1'b0;
    wait_cyc(20);

    for (int i = 0; i < vecs.size(); i++) begin
      b0 = bv_tot; f0 = fe_tot;
      send_frame(vecs[i].code, vecs[i].flip_par, -1);
      wait_cyc(5);
      if (vecs[i].exp_bv != 0) prev_good = vecs[i].code;
      check($sformatf("vec%0d held", i), {19'd0, held_keys}, {19'd0, vecs[i].exp_held});
      check($sformatf("vec%0d byte_valid count", i), bv_tot - b0, vecs[i].exp_bv);
      check($sformatf("vec%0d frame_err count", i), fe_tot - f0, vecs[i].exp_fe);
      check($sformatf("vec%0d byte_data", i), {24'd0, byte_data}, {24'd0, prev_good});
    end

    // Timeout: start bit + 4 data bits of 0x2E, then stall
    b0 = bv_tot; f0 = fe_tot;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h2E >> i), 0);
    wait_cyc(300);
    check("timeout frame_err count", fe_tot - f0, 1);
    check("timeout byte_valid count", bv_tot - b0, 0);
    check("timeout held", {19'd0, held_keys}, 32'h0);
    send_frame(8'h2E, 0, -1);
    wait_cyc(5);
    check("post-timeout held", {19'd0, held_keys}, 32'h0010);
    check("post-timeout byte_data", {24'd0, byte_data}, 32'h2E);

    // Reset mid-frame with a key held
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    rst = 1'b1;
    wait_cyc(1);
    check("midreset held", {19'd0, held_keys}, 32'h0);
    check("midreset byte_data", {24'd0, byte_data}, 32'h0);
    check("midreset byte_valid", {31'd0, byte_valid}, 32'h0);
    check("midreset frame_err", {31'd0, frame_err}, 32'h0);
    rst = 1'b0;
    ps2_data = 1'b1;
    wait_cyc(20);
    b0 = bv_tot; f0 = fe_tot;
    send_frame(8'h3D, 0, -1);
    wait_cyc(5);
    check("post-reset held", {19'd0, held_keys}, 32'h0040);
    check("post-reset frame_err count", fe_tot - f0, 0);

    // Short ps2_clk glitch mid-frame must be filtered out
    b0 = bv_tot; f0 = fe_tot;
    send_frame(8'h1E, 0, 4);
    wait_cyc(5);
    check("glitch held", {19'd0, held_keys}, 32'h0042);
    check("glitch byte_data", {24'd0, byte_data}, 32'h1E);
    check("glitch byte_valid count", bv_tot - b0, 1);
    check("glitch frame_err count", fe_tot - f0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
